// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: RV32I instruction-fetch stage.
// Owns the fetch PC and issues in-order word requests over a valid/ready channel.
// Responses may arrive any number of cycles later; they are buffered with their PCs
// and presented to the IF/ID register. A redirect squashes the buffer, and responses
// still in flight for the old path are counted and then discarded.
// Optional feature: define FETCH_ALIGN_CHECK_EN to turn a misaligned redirect target
// into a single trap entry (misaligned_F) instead of silently aligning it.
module pipe_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        sync_reset,
   input  logic        stall_F,
   input  logic        redirect_E,
   input  logic [31:0] redirect_target_E,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instruction_F,
   output logic [31:0] PC_F,
   output logic [31:0] PC_4_F,
   output logic        valid_F,
   output logic        misaligned_F
);

   localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // Advance a circular-buffer pointer by n slots (n never exceeds DEPTH).
   function automatic ptr_t ptr_add(input ptr_t p, input cnt_t n);
      logic [31:0] s;
      s = 32'(p) + 32'(n);
      if (s >= DEPTH) s = s - DEPTH;
      return ptr_t'(s);
   endfunction

   logic [31:0] fetch_pc;
   logic [31:0] buf_pc    [DEPTH];
   logic [31:0] buf_instr [DEPTH];
   ptr_t        head_ptr;
   ptr_t        tail_ptr;
   ptr_t        fill_ptr;
   // Entries are filled strictly in allocation order, so the filled entries always
   // form a run starting at the head and a count is enough to track them.
   cnt_t        alloc_cnt;
   cnt_t        filled_cnt;
   cnt_t        drop_cnt;
   cnt_t        unfilled_cnt;
   logic        fetch_lock;
   logic        credit_ok;
   logic        req_fire;
   logic        resp_drop;
   logic        resp_fill;
   logic        deq;
   logic        target_misal;
   logic [31:0] target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        buf_misal [DEPTH];

   assign target_misal = (redirect_target_E[1:0] != 2'b00);
   assign target_pc    = redirect_target_E;
`else
   logic        unused_target_low;

   assign target_misal      = 1'b0;
   assign target_pc         = {redirect_target_E[31:2], 2'b00};
   assign unused_target_low = ^redirect_target_E[1:0];
`endif

   assign unfilled_cnt = alloc_cnt - filled_cnt;
   assign fill_ptr     = ptr_add(head_ptr, filled_cnt);
   assign valid_F      = (filled_cnt != '0);
   assign deq          = valid_F & ~stall_F & ~redirect_E;

   // A head leaving this cycle frees its slot for a new request in the same cycle,
   // which is what sustains one word per cycle at single-cycle memory latency.
   assign credit_ok      = ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < (DEPTH_C + (CW + 1)'(deq));
   assign imem_req_valid = sync_reset & ~redirect_E & ~fetch_lock & credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses owed to a squashed path are consumed before any live entry is filled.
   assign resp_drop = imem_resp_valid & (drop_cnt != '0);
   assign resp_fill = imem_resp_valid & (drop_cnt == '0) & (unfilled_cnt != '0);

   // Present the head entry, or a NOP bubble with zero PCs while it is not yet filled.
   // NOTE: every output gets a default before the if, so no latch is inferred.
   always_comb begin
      instruction_F = NOP_INSTR;
      PC_F          = '0;
      PC_4_F        = '0;
      if (valid_F) begin
         instruction_F = buf_instr[head_ptr];
         PC_F          = buf_pc[head_ptr];
         PC_4_F        = buf_pc[head_ptr] + 32'd4;
      end
   end

   // Occupancy, pointers, drop credit and fetch PC; redirect outranks everything else.
   // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clock) begin
      if (!sync_reset) begin
         fetch_pc   <= RESET_PC;
         head_ptr   <= '0;
         tail_ptr   <= '0;
         alloc_cnt  <= '0;
         filled_cnt <= '0;
         drop_cnt   <= '0;
      end else if (redirect_E) begin
         fetch_pc <= target_pc;
         head_ptr <= '0;
         // Every unfilled entry has a response still coming; one arriving right now is absorbed.
         drop_cnt <= drop_cnt + unfilled_cnt - cnt_t'(resp_drop | resp_fill);
         if (target_misal) begin
            tail_ptr   <= ptr_t'(1);
            alloc_cnt  <= cnt_t'(1);
            filled_cnt <= cnt_t'(1);
         end else begin
            tail_ptr   <= '0;
            alloc_cnt  <= '0;
            filled_cnt <= '0;
         end
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
            tail_ptr <= ptr_add(tail_ptr, cnt_t'(1));
         end
         if (deq) head_ptr <= ptr_add(head_ptr, cnt_t'(1));
         if (resp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
         alloc_cnt  <= alloc_cnt + cnt_t'(req_fire) - cnt_t'(deq);
         filled_cnt <= filled_cnt + cnt_t'(resp_fill) - cnt_t'(deq);
      end
   end

   // Capture request PCs at the tail and returned words at the oldest unfilled slot.
   // NOTE: the payload arrays are not reset; the occupancy counters alone decide what is visible.
   always_ff @(posedge clock) begin
      if (sync_reset) begin
         if (redirect_E) begin
            if (target_misal) begin
               buf_pc[0]    <= target_pc;
               buf_instr[0] <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
               buf_misal[0] <= 1'b1;
`endif
            end
         end else begin
            if (req_fire) begin
               buf_pc[tail_ptr] <= fetch_pc;
`ifdef FETCH_ALIGN_CHECK_EN
               buf_misal[tail_ptr] <= 1'b0;
`endif
            end
            if (resp_fill) buf_instr[fill_ptr] <= imem_resp_data;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Hold off fetching while a misaligned trap entry is pending; only a redirect releases it.
   always_ff @(posedge clock) begin
      if (!sync_reset)     fetch_lock <= 1'b0;
      else if (redirect_E) fetch_lock <= target_misal;
   end

   assign misaligned_F = valid_F & buf_misal[head_ptr];
`else
   assign fetch_lock   = 1'b0;
   assign misaligned_F = 1'b0;
`endif

endmodule
